// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin two-port request/ack arbiter that is the sole
//            driver of the data_mem strobes, address and write data.
//            Port 0 = CPU load/store stage, port 1 = debug/DMA loader.
//            One access in flight: IDLE -> ACCESS -> RESP -> IDLE.
// Options  : define DMEM_ARB_BOUNDS_EN to reject addresses >= SIZE with an
//            error response instead of a memory access.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int SIZE = 1024,
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic            req1,
    input  logic            we0,
    input  logic            we1,
    input  logic [WORD-1:0] addr0,
    input  logic [WORD-1:0] addr1,
    input  logic [WORD-1:0] wdata0,
    input  logic [WORD-1:0] wdata1,
    output logic            ack0,
    output logic            ack1,
    output logic [WORD-1:0] rdata0,
    output logic [WORD-1:0] rdata1,
    output logic            err0,
    output logic            err1,
    output logic            busy,
    output logic            mem_write,
    output logic            mem_read,
    output logic [WORD-1:0] mem_address,
    output logic [WORD-1:0] mem_write_data,
    input  logic [WORD-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_id_q, gnt_id_d;
    logic              we_q, we_d;
    logic              oob_q, oob_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err0_q, err0_d;
    logic              err1_q, err1_d;
    logic [WORD-1:0]   rdata0_q, rdata0_d;
    logic [WORD-1:0]   rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic [WORD-1:0]   mem_address_q, mem_address_d;
    logic [WORD-1:0]   mem_write_data_q, mem_write_data_d;

    // Selected requester: on a tie the port that did not win last time.
    logic              w_any_req;
    logic              w_gnt;
    logic              w_sel_we;
    logic [WORD-1:0]   w_sel_addr;
    logic [WORD-1:0]   w_sel_wdata;
    logic              w_sel_oob;
    logic              w_rdata_upd;
    logic [WORD-1:0]   w_resp_data;

    assign w_any_req   = req0 | req1;
    assign w_gnt       = req1 & (~req0 | ~last_gnt_q);
    assign w_sel_we    = w_gnt ? we1    : we0;
    assign w_sel_addr  = w_gnt ? addr1  : addr0;
    assign w_sel_wdata = w_gnt ? wdata1 : wdata0;

`ifdef DMEM_ARB_BOUNDS_EN
    localparam logic [WORD-1:0] c_SIZE = WORD'(SIZE);
    assign w_sel_oob = (w_sel_addr >= c_SIZE);
`else
    assign w_sel_oob = 1'b0;
`endif

    // Rejected accesses return zero data; reads return the memory word;
    // successful writes leave the requester's rdata untouched.
    assign w_rdata_upd = oob_q | ~we_q;
    assign w_resp_data = oob_q ? '0 : mem_read_data;

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d          = state_q;
        last_gnt_d       = last_gnt_q;
        gnt_id_d         = gnt_id_q;
        we_d             = we_q;
        oob_d            = oob_q;
        ack0_d           = 1'b0;
        ack1_d           = 1'b0;
        err0_d           = 1'b0;
        err1_d           = 1'b0;
        rdata0_d         = rdata0_q;
        rdata1_d         = rdata1_q;
        mem_write_d      = 1'b0;
        mem_read_d       = 1'b0;
        mem_address_d    = '0;
        mem_write_data_d = '0;

        case (state_q)
            IDLE: begin
                if (w_any_req) begin
                    // Address and write data are held directly in the
                    // memory-facing registers for the ACCESS cycle.
                    state_d          = ACCESS;
                    gnt_id_d         = w_gnt;
                    we_d             = w_sel_we;
                    oob_d            = w_sel_oob;
                    mem_address_d    = w_sel_addr;
                    mem_write_data_d = w_sel_wdata;
                    mem_write_d      = w_sel_we & ~w_sel_oob;
                    mem_read_d       = ~w_sel_we & ~w_sel_oob;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!gnt_id_q) begin
                    ack0_d = 1'b1;
                    err0_d = oob_q;
                    if (w_rdata_upd) begin
                        rdata0_d = w_resp_data;
                    end
                end else begin
                    ack1_d = 1'b1;
                    err1_d = oob_q;
                    if (w_rdata_upd) begin
                        rdata1_d = w_resp_data;
                    end
                end
            end
            RESP: begin
                state_d    = IDLE;
                last_gnt_d = gnt_id_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset low aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            last_gnt_q       <= 1'b1;
            gnt_id_q         <= 1'b0;
            we_q             <= 1'b0;
            oob_q            <= 1'b0;
            ack0_q           <= 1'b0;
            ack1_q           <= 1'b0;
            err0_q           <= 1'b0;
            err1_q           <= 1'b0;
            rdata0_q         <= '0;
            rdata1_q         <= '0;
            busy_q           <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            last_gnt_q       <= last_gnt_d;
            gnt_id_q         <= gnt_id_d;
            we_q             <= we_d;
            oob_q            <= oob_d;
            ack0_q           <= ack0_d;
            ack1_q           <= ack1_d;
            err0_q           <= err0_d;
            err1_q           <= err1_d;
            rdata0_q         <= rdata0_d;
            rdata1_q         <= rdata1_d;
            busy_q           <= busy_d;
            mem_write_q      <= mem_write_d;
            mem_read_q       <= mem_read_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign ack0           = ack0_q;
    assign ack1           = ack1_q;
    assign err0           = err0_q;
    assign err1           = err1_q;
    assign rdata0         = rdata0_q;
    assign rdata1         = rdata1_q;
    assign busy           = busy_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Scoreboard bench for dmem_arbiter with a behavioural data_mem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1, busy;
    logic [31:0] rdata0, rdata1;
    logic        mem_write, mem_read;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [0:1023];
    logic [31:0] hold0, hold1;

    always #5 clk = ~clk;

    dmem_arbiter #(.SIZE(1024), .WORD(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .busy(busy),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    // Behavioural data_mem: combinational read, write on the rising edge.
    logic [31:0] mem [0:1023];
    assign mem_read_data = mem[mem_address[9:0]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[9:0]] <= mem_write_data;
    end

    // Protocol watcher: strobe overlap, ack overlap, strobes while idle.
    always @(negedge clk) begin
        if (reset && ((mem_write && mem_read) || (ack0 && ack1) ||
                      ((mem_write || mem_read) && !busy)))
            viol <= viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected response for a request, pushed when the request is driven.
    task automatic push_exp(input int port, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic oob;
`ifdef DMEM_ARB_BOUNDS_EN
        oob = (a >= 32'd1024);
`else
        oob = 1'b0;
`endif
        e.err = oob;
        if (oob) begin
            e.data = '0;
        end else if (w) begin
            model[a[9:0]] = d;
            e.data = (port == 0) ? hold0 : hold1;
        end else begin
            e.data = model[a[9:0]];
        end
        if (port == 0) begin hold0 = e.data; q0.push_back(e); end
        else           begin hold1 = e.data; q1.push_back(e); end
    endtask

    task automatic do_reset();
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        reset = 1'b1;
        hold0 = '0; hold1 = '0;
        q0.delete(); q1.delete();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        total++;
        if ({ack0, ack1, err0, err1, mem_write, mem_read} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000",
                     {ack0, ack1, err0, err1, mem_write, mem_read});
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        total++;
        if ({mem_address, mem_write_data, rdata0, rdata1} !== 128'b0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h %h want all 0",
                     mem_address, mem_write_data, rdata0, rdata1);
        end
        reset = 1'b1;
        hold0 = '0; hold1 = '0;
        tick(); tick();
        total++;
        if ({busy, mem_write, mem_read} !== 3'b0) begin
            bad++;
            $display("FAIL idle_after_release: got %b want 000",
                     {busy, mem_write, mem_read});
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hDEADBEEF;
        push_exp(0, 1'b1, 32'd5, 32'hDEADBEEF);
        tick();
        total++;
        if ({mem_write, mem_read, mem_address, mem_write_data} !==
            {2'b10, 32'd5, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL wr_access: got w=%b r=%b a=%h d=%h want w=1 r=0 a=5 d=deadbeef",
                     mem_write, mem_read, mem_address, mem_write_data);
        end
        tick();
        e = q0.pop_front();
        total++;
        if ({ack0, mem_write, rdata0, err0} !== {2'b10, e.data, e.err}) begin
            bad++;
            $display("FAIL wr_ack: got ack=%b w=%b rdata=%h err=%b want ack=1 w=0 rdata=%h err=%b",
                     ack0, mem_write, rdata0, err0, e.data, e.err);
        end
        req0 = 1'b0;
        tick();
        total++;
        if (ack0 !== 1'b0) begin
            bad++; $display("FAIL ack_width: got %b want 0", ack0);
        end
        req0 = 1'b1; we0 = 1'b0;
        push_exp(0, 1'b0, 32'd5, 32'h0);
        tick();
        total++;
        if ({mem_read, mem_write, mem_address} !== {2'b10, 32'd5}) begin
            bad++;
            $display("FAIL rd_access: got r=%b w=%b a=%h want r=1 w=0 a=5",
                     mem_read, mem_write, mem_address);
        end
        tick();
        e = q0.pop_front();
        total++;
        if ({ack0, rdata0, err0} !== {1'b1, e.data, e.err} || rdata0 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_ack: got ack=%b rdata=%h err=%b want ack=1 rdata=%h err=%b",
                     ack0, rdata0, err0, e.data, e.err);
        end
        req0 = 1'b0;
        tick(); tick();
        total++;
        if (rdata0 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_hold: got %h want deadbeef", rdata0);
        end
    endtask

    task automatic test_tie_from_reset();
        exp_t e;
        int   a0 = -1;
        int   a1 = -1;
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd8; wdata1 = 32'h33334444;
        push_exp(0, 1'b0, 32'd5, 32'h0);
        push_exp(1, 1'b1, 32'd8, 32'h33334444);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ack0 && q0.size() > 0) begin
                a0 = i; e = q0.pop_front(); req0 = 1'b0;
                total++;
                if ({rdata0, err0} !== {e.data, e.err}) begin
                    bad++;
                    $display("FAIL tie_rdata0: got %h/%b want %h/%b",
                             rdata0, err0, e.data, e.err);
                end
            end
            if (ack1 && q1.size() > 0) begin
                a1 = i; e = q1.pop_front(); req1 = 1'b0;
                total++;
                if ({rdata1, err1} !== {e.data, e.err}) begin
                    bad++;
                    $display("FAIL tie_rdata1: got %h/%b want %h/%b",
                             rdata1, err1, e.data, e.err);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        total++;
        if (a0 !== 2 || a1 !== 5) begin
            bad++;
            $display("FAIL tie_order: got ack0@%0d ack1@%0d want ack0@2 ack1@5", a0, a1);
        end
    endtask

    task automatic test_back_to_back();
        logic        w0 [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] ad0[3] = '{32'd10, 32'd10, 32'd11};
        logic [31:0] d0 [3] = '{32'hA0A00001, 32'h0, 32'hA0A00003};
        logic        w1 [3] = '{1'b1, 1'b0, 1'b0};
        logic [31:0] ad1[3] = '{32'd20, 32'd20, 32'd11};
        logic [31:0] d1 [3] = '{32'hB0B00002, 32'h0, 32'h0};
        int          order[6] = '{0, 1, 0, 1, 0, 1};
        int          n = 0;
        int          i0 = 0;
        int          i1 = 0;
        int          v0;
        exp_t        e;
        do_reset();
        v0 = viol;
        req0 = 1'b1; we0 = w0[0]; addr0 = ad0[0]; wdata0 = d0[0];
        req1 = 1'b1; we1 = w1[0]; addr1 = ad1[0]; wdata1 = d1[0];
        push_exp(0, w0[0], ad0[0], d0[0]);
        push_exp(1, w1[0], ad1[0], d1[0]);
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick();
            if (ack0 && q0.size() > 0) begin
                e = q0.pop_front();
                total++;
                if ({rdata0, err0} !== {e.data, e.err} || order[n] !== 0) begin
                    bad++;
                    $display("FAIL b2b_port0 #%0d: got %h/%b port 0 want %h/%b port %0d",
                             n, rdata0, err0, e.data, e.err, order[n]);
                end
                n++; i0++;
                if (i0 < 3) begin
                    we0 = w0[i0]; addr0 = ad0[i0]; wdata0 = d0[i0];
                    push_exp(0, w0[i0], ad0[i0], d0[i0]);
                end else req0 = 1'b0;
            end
            if (ack1 && q1.size() > 0 && n < 6) begin
                e = q1.pop_front();
                total++;
                if ({rdata1, err1} !== {e.data, e.err} || order[n] !== 1) begin
                    bad++;
                    $display("FAIL b2b_port1 #%0d: got %h/%b port 1 want %h/%b port %0d",
                             n, rdata1, err1, e.data, e.err, order[n]);
                end
                n++; i1++;
                if (i1 < 3) begin
                    we1 = w1[i1]; addr1 = ad1[i1]; wdata1 = d1[i1];
                    push_exp(1, w1[i1], ad1[i1], d1[i1]);
                end else req1 = 1'b0;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        total++;
        if (n !== 6) begin
            bad++; $display("FAIL b2b_count: got %0d acks want 6", n);
        end
        total++;
        if (viol !== v0) begin
            bad++; $display("FAIL protocol_overlap: got %0d violations want 0", viol - v0);
        end
    endtask

    task automatic test_reset_abort();
        int first = -1;
        int seen = 0;
        do_reset();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd20;
        tick();
        total++;
        if (mem_read !== 1'b1) begin
            bad++; $display("FAIL abort_pre: got mem_read=%b want 1", mem_read);
        end
        reset = 1'b0;
        tick();
        total++;
        if ({mem_read, mem_write, ack1, busy} !== 4'b0 || rdata1 !== 32'h0) begin
            bad++;
            $display("FAIL abort_strobes: got r=%b w=%b ack1=%b busy=%b rdata1=%h want all 0",
                     mem_read, mem_write, ack1, busy, rdata1);
        end
        reset = 1'b1; req1 = 1'b0;
        hold0 = '0; hold1 = '0; q0.delete(); q1.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ack1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL abort_no_ack: got %0d ack1 pulses want 0", seen);
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd20;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack0) begin req0 = 1'b0; if (first < 0) first = 0; end
            if (ack1) begin req1 = 1'b0; if (first < 0) first = 1; end
        end
        total++;
        if (first !== 0) begin
            bad++; $display("FAIL abort_tie_order: got first port %0d want 0", first);
        end
    endtask

    task automatic test_bounds();
        exp_t e;
        logic want_rd;
        int   got_rd = 0;
`ifdef DMEM_ARB_BOUNDS_EN
        want_rd = 1'b0;
`else
        want_rd = 1'b1;
`endif
        do_reset();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd0; wdata1 = 32'h0BADF00D;
        push_exp(1, 1'b1, 32'd0, 32'h0BADF00D);
        tick(); tick();
        e = q1.pop_front();
        total++;
        if ({ack1, err1} !== {1'b1, e.err}) begin
            bad++; $display("FAIL inrange_err: got ack1=%b err1=%b want 1/%b", ack1, err1, e.err);
        end
        req1 = 1'b0;
        tick();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd1024;
        push_exp(1, 1'b0, 32'd1024, 32'h0);
        tick();
        if (mem_read) got_rd = 1;
        total++;
        if (mem_read !== want_rd || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL oob_strobe: got r=%b w=%b want r=%b w=0", mem_read, mem_write, want_rd);
        end
        tick();
        e = q1.pop_front();
        total++;
        if ({ack1, rdata1, err1} !== {1'b1, e.data, e.err}) begin
            bad++;
            $display("FAIL oob_resp: got ack1=%b rdata1=%h err1=%b want 1/%h/%b",
                     ack1, rdata1, err1, e.data, e.err);
        end
        req1 = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie_from_reset();
        test_back_to_back();
        test_reset_abort();
        test_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
